dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data-memory bus between two requesters: the pipeline MEM stage (CPU port) and a DMA/loader engine (DMA port).
- Sequences each access as a command phase followed by a read-data wait.
- Generates cpu_stall for the pipeline hazard logic, which uses it to freeze PC, IF/ID, ID/EX and EX/MEM.
- Sits between EX/MEM outputs and the memory/peripheral bus.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from mem_rd to valid mem_rdata; legal values 1..4.
- STARVE_LIMIT, 4, consecutive contested CPU wins before the DMA is forced to win; minimum 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request (level).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; valid only while cpu_done is high.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_stall  out  1  combinational: cpu_req & ~cpu_done.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_done  same meaning as the CPU port, for the DMA port.
- mem_rd  out  1  read command.
- mem_wr  out  1  write command.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: every output register is 0, FSM is IDLE, starve_cnt is 0. Reset mid-transaction abandons the access; no done pulse is produced.
- States:
  - IDLE: arbitrate. If any request is present, latch the winner (owner, we, addr, wdata) and go to CMD. Otherwise stay in IDLE.
  - CMD: mem_addr/mem_wdata come from the latched values; mem_wr=we and mem_rd=~we for exactly this one cycle.
    - Write: the owner's done is high in this same cycle; next state is IDLE.
    - Read: load the latency counter with MEM_LAT-1; next state is RD_WAIT.
  - RD_WAIT: decrement the counter each cycle. When it reaches 0, drive the owner's rdata from mem_rdata and pulse done for one cycle; next state is IDLE.
  - In IDLE and RD_WAIT, mem_rd=mem_wr=0 and mem_addr/mem_wdata hold their last values.
- Latency, request seen in IDLE at cycle T:
  - Write: done at T+1.
  - Read: done at T+1+MEM_LAT.
  - Minimum spacing is one access per 2 cycles (write) or 2+MEM_LAT cycles (read).
- Arbitration (IDLE only):
  - CPU has fixed priority.
  - A contested CPU win (both requests high) increments starve_cnt, which saturates at STARVE_LIMIT.
  - When starve_cnt == STARVE_LIMIT and both requests are high, the DMA wins.
  - Any DMA grant clears starve_cnt.
  - An uncontested CPU grant leaves starve_cnt unchanged.
  - starve_cnt width: $clog2(STARVE_LIMIT+1).
- Handshake rules:
  - A requester holds req, we, addr and wdata stable until its done pulse.
  - Dropping req before a grant withdraws the request.
  - After a grant, the access always completes and done still pulses.
  - done never pulses to a non-owner.
  - rdata outputs hold their last value when done is low.
- The arbiter does not decode address ranges; the peripheral bus handles decoding.

Optional Feature:
- Macro: ARB_STAT_EN.
- Defined:
  - Adds outputs stat_cpu_stall_cyc[15:0] and stat_dma_grants[15:0], both free-running and wrapping at 16'hFFFF→0, both cleared by reset.
  - stat_cpu_stall_cyc increments every cycle that cpu_stall is high.
  - stat_dma_grants increments on each DMA grant.
- Undefined: these ports and their counters do not exist. Functional behaviour is identical in both cases.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, CMD=2'd1, RD_WAIT=2'd2.
  - Owner encoding: OWN_CPU=1'b0, OWN_DMA=1'b1.
  - Defaults for MEM_LAT and STARVE_LIMIT.
- One natural sub-module: arb_prio_starve, the combinational winner select plus the starve_cnt register. Port muxing and the FSM stay in dmem_arbiter.

Test Plan:
- CPU write alone (MEM_LAT=1): cpu_req=1, we=1, addr=32'h10, wdata=32'hDEADBEEF at T → at T+1: mem_wr=1, mem_addr=32'h10, cpu_done=1; cpu_stall=1 at T and 0 at T+1.
- CPU read with MEM_LAT=3: request at T, memory returns 32'h12345678 → mem_rd=1 only at T+1; cpu_done=1 and cpu_rdata=32'h12345678 at T+4; cpu_stall high for T..T+3.
- Contention with STARVE_LIMIT=2, both requesting back-to-back writes → grant order CPU, CPU, DMA, CPU, CPU, DMA; dma_done never coincides with cpu_done.
- Withdraw: dma_req pulses for 1 cycle while the CPU owns the bus in RD_WAIT → no DMA command and no dma_done issued.
- Async reset asserted in RD_WAIT → all outputs 0 immediately (no clock edge); after release, IDLE with no stale done; a fresh CPU write completes in 1 cycle.
- ARB_STAT_EN defined: 3 CPU reads with MEM_LAT=1 plus 2 DMA writes, no overlap → stat_cpu_stall_cyc=6, stat_dma_grants=2.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and defaults for the data-memory bus arbiter.
// The optional ARB_STAT_EN statistics build uses the same package.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int MEM_LAT_DEF      = 1;
    localparam int STARVE_LIMIT_DEF = 4;

    // Read latency counter holds MEM_LAT-1, which never exceeds 3.
    localparam int LAT_W = 2;

    function automatic logic [LAT_W-1:0] lat_preload(input int mem_lat);
        return LAT_W'(mem_lat - 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_arb_prio_starve.sv
// Fixed-priority CPU/DMA winner select with a starvation counter that
// hands the bus to the DMA after STARVE_LIMIT consecutive contested CPU wins.
module arb_prio_starve
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)(
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic cpu_req,
    input  logic dma_req,
    output logic grant_valid,
    output logic grant_owner
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             contested_s;
    logic             starve_full_s;

    assign contested_s   = cpu_req & dma_req;
    assign starve_full_s = (starve_cnt_r == LIMIT_C);

    // Winner select: CPU first unless the DMA has been starved long enough.
    always_comb begin
        grant_valid = cpu_req | dma_req;
        if (contested_s && starve_full_s) begin
            grant_owner = OWN_DMA;
        end else if (cpu_req) begin
            grant_owner = OWN_CPU;
        end else if (dma_req) begin
            grant_owner = OWN_DMA;
        end else begin
            grant_owner = OWN_CPU;
        end
    end

    // Starvation counter: counts contested CPU wins, cleared by any DMA grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (arb_en && grant_valid) begin
            if (grant_owner == OWN_DMA) begin
                starve_cnt_r <= {CNT_W{1'b0}};
            end else if (contested_s && !starve_full_s) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data-memory bus between the CPU MEM stage and a DMA
// engine. Define ARB_STAT_EN to add stall-cycle and DMA-grant counters.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = MEM_LAT_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_STAT_EN
    output logic [15:0]       stat_cpu_stall_cyc,
    output logic [15:0]       stat_dma_grants,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_r;
    logic              owner_r;
    logic              we_r;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic              mem_rd_r;
    logic              mem_wr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              cpu_done_r;
    logic              dma_done_r;
    logic [DATA_W-1:0] cpu_rdata_hold_r;
    logic [DATA_W-1:0] dma_rdata_hold_r;

    logic              arb_en_s;
    logic              grant_valid_s;
    logic              grant_owner_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              rd_done_s;
    logic              last_lat_s;

    assign arb_en_s = (state_r == IDLE);

    arb_prio_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .arb_en      (arb_en_s),
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .grant_valid (grant_valid_s),
        .grant_owner (grant_owner_s)
    );

    assign sel_we_s    = (grant_owner_s == OWN_DMA) ? dma_we    : cpu_we;
    assign sel_addr_s  = (grant_owner_s == OWN_DMA) ? dma_addr  : cpu_addr;
    assign sel_wdata_s = (grant_owner_s == OWN_DMA) ? dma_wdata : cpu_wdata;

    // Done is registered one cycle early so it lines up with the data-valid cycle.
    assign last_lat_s = (MEM_LAT == 1);

    // Access sequencer: arbitrate, issue one command cycle, then wait out read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= IDLE;
            owner_r          <= OWN_CPU;
            we_r             <= 1'b0;
            lat_cnt_r        <= {LAT_W{1'b0}};
            mem_rd_r         <= 1'b0;
            mem_wr_r         <= 1'b0;
            mem_addr_r       <= {ADDR_W{1'b0}};
            mem_wdata_r      <= {DATA_W{1'b0}};
            cpu_done_r       <= 1'b0;
            dma_done_r       <= 1'b0;
            cpu_rdata_hold_r <= {DATA_W{1'b0}};
            dma_rdata_hold_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        owner_r     <= grant_owner_s;
                        we_r        <= sel_we_s;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                        mem_wr_r    <= sel_we_s;
                        mem_rd_r    <= ~sel_we_s;
                        cpu_done_r  <= sel_we_s & (grant_owner_s == OWN_CPU);
                        dma_done_r  <= sel_we_s & (grant_owner_s == OWN_DMA);
                        state_r     <= CMD;
                    end else begin
                        mem_wr_r    <= 1'b0;
                        mem_rd_r    <= 1'b0;
                        cpu_done_r  <= 1'b0;
                        dma_done_r  <= 1'b0;
                    end
                end
                CMD: begin
                    mem_wr_r <= 1'b0;
                    mem_rd_r <= 1'b0;
                    if (we_r) begin
                        cpu_done_r <= 1'b0;
                        dma_done_r <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        lat_cnt_r  <= lat_preload(MEM_LAT);
                        cpu_done_r <= last_lat_s & (owner_r == OWN_CPU);
                        dma_done_r <= last_lat_s & (owner_r == OWN_DMA);
                        state_r    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt_r == {LAT_W{1'b0}}) begin
                        if (owner_r == OWN_CPU) begin
                            cpu_rdata_hold_r <= mem_rdata;
                        end else begin
                            dma_rdata_hold_r <= mem_rdata;
                        end
                        cpu_done_r <= 1'b0;
                        dma_done_r <= 1'b0;
                        state_r    <= IDLE;
                    end else begin
                        lat_cnt_r  <= lat_cnt_r - LAT_W'(1);
                        cpu_done_r <= (lat_cnt_r == LAT_W'(1)) & (owner_r == OWN_CPU);
                        dma_done_r <= (lat_cnt_r == LAT_W'(1)) & (owner_r == OWN_DMA);
                    end
                end
                default: begin
                    mem_wr_r   <= 1'b0;
                    mem_rd_r   <= 1'b0;
                    cpu_done_r <= 1'b0;
                    dma_done_r <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    // Read data arrives on mem_rdata in the done cycle itself, so it is passed through then and held after.
    assign rd_done_s = (state_r == RD_WAIT);
    assign cpu_rdata = (cpu_done_r && rd_done_s) ? mem_rdata : cpu_rdata_hold_r;
    assign dma_rdata = (dma_done_r && rd_done_s) ? mem_rdata : dma_rdata_hold_r;

    assign cpu_done  = cpu_done_r;
    assign dma_done  = dma_done_r;
    assign cpu_stall = cpu_req & ~cpu_done_r;
    assign mem_rd    = mem_rd_r;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

`ifdef ARB_STAT_EN
    logic [15:0] stat_stall_r;
    logic [15:0] stat_grant_r;

    // Free-running statistics counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_stall_r <= 16'd0;
            stat_grant_r <= 16'd0;
        end else begin
            if (cpu_stall) begin
                stat_stall_r <= stat_stall_r + 16'd1;
            end else begin
                stat_stall_r <= stat_stall_r;
            end
            if (arb_en_s && grant_valid_s && (grant_owner_s == OWN_DMA)) begin
                stat_grant_r <= stat_grant_r + 16'd1;
            end else begin
                stat_grant_r <= stat_grant_r;
            end
        end
    end

    assign stat_cpu_stall_cyc = stat_stall_r;
    assign stat_dma_grants    = stat_grant_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (MEM_LAT=3, STARVE_LIMIT=2).
// Statistics checks are compiled only when ARB_STAT_EN is defined.
module tb_dmem_arbiter;

    localparam int MEM_LAT      = 3;
    localparam int STARVE_LIMIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_done, cpu_stall, dma_done, mem_rd, mem_wr;
`ifdef ARB_STAT_EN
    logic [15:0] stat_cpu_stall_cyc, stat_dma_grants;
`endif

    logic [31:0] rd_value;
    logic [2:0]  rd_pipe = 3'b000;

    int n_checks = 0;
    int n_errors = 0;

    int          n_grants;
    logic [5:0]  order;
    logic        flag;

    dmem_arbiter #(
        .ADDR_W (32), .DATA_W (32), .MEM_LAT (MEM_LAT), .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk), .reset (reset),
        .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata), .cpu_done (cpu_done), .cpu_stall (cpu_stall),
        .dma_req (dma_req), .dma_we (dma_we), .dma_addr (dma_addr), .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata), .dma_done (dma_done),
        .mem_rd (mem_rd), .mem_wr (mem_wr), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
`ifdef ARB_STAT_EN
        .stat_cpu_stall_cyc (stat_cpu_stall_cyc), .stat_dma_grants (stat_dma_grants),
`endif
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data is valid exactly MEM_LAT cycles after mem_rd.
    always @(posedge clk) rd_pipe <= {rd_pipe[1:0], mem_rd};
    assign mem_rdata = rd_pipe[MEM_LAT-1] ? rd_value : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        rd_value = 32'h0;
        step();
        step();
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cpu_done", {31'd0, cpu_done}, 32'd0);
        chk("rst_dma_done", {31'd0, dma_done}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        reset = 1'b0;
        step();

        // CPU write alone: done one cycle after the request.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_stall_T", {31'd0, cpu_stall}, 32'd1);
        chk("wr_no_cmd_T", {31'd0, mem_wr}, 32'd0);
        step();
        chk("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("wr_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("wr_mem_addr", mem_addr, 32'h10);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_cpu_done", {31'd0, cpu_done}, 32'd1);
        chk("wr_dma_done", {31'd0, dma_done}, 32'd0);
        chk("wr_stall_T1", {31'd0, cpu_stall}, 32'd0);
        cpu_req = 1'b0;
        step();
        chk("wr_done_cleared", {31'd0, cpu_done}, 32'd0);
        chk("wr_cmd_cleared", {31'd0, mem_wr}, 32'd0);
        chk("wr_addr_held", mem_addr, 32'h10);

        // CPU read with MEM_LAT=3: command at T+1, done at T+4.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20; rd_value = 32'h12345678;
        #1;
        chk("rd_stall_T", {31'd0, cpu_stall}, 32'd1);
        step();
        chk("rd_mem_rd_T1", {31'd0, mem_rd}, 32'd1);
        chk("rd_mem_addr", mem_addr, 32'h20);
        chk("rd_stall_T1", {31'd0, cpu_stall}, 32'd1);
        step();
        chk("rd_mem_rd_T2", {31'd0, mem_rd}, 32'd0);
        chk("rd_done_T2", {31'd0, cpu_done}, 32'd0);
        step();
        chk("rd_done_T3", {31'd0, cpu_done}, 32'd0);
        chk("rd_stall_T3", {31'd0, cpu_stall}, 32'd1);
        step();
        chk("rd_done_T4", {31'd0, cpu_done}, 32'd1);
        chk("rd_rdata_T4", cpu_rdata, 32'h12345678);
        chk("rd_stall_T4", {31'd0, cpu_stall}, 32'd0);
        cpu_req = 1'b0;
        step();
        chk("rd_done_T5", {31'd0, cpu_done}, 32'd0);
        chk("rd_rdata_held", cpu_rdata, 32'h12345678);

        // Contention: both stream writes; expect CPU, CPU, DMA, CPU, CPU, DMA.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'h11111111;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h200; dma_wdata = 32'h22222222;
        n_grants = 0; order = 6'b000000; flag = 1'b0;
        for (int c = 0; c < 40 && n_grants < 6; c++) begin
            step();
            if (cpu_done && dma_done) flag = 1'b1;
            if (dma_done) begin
                chk("cont_dma_addr", mem_addr, dma_addr);
                order[n_grants] = 1'b1;
                n_grants++;
                dma_addr = dma_addr + 32'd4;
            end else if (cpu_done) begin
                chk("cont_cpu_addr", mem_addr, cpu_addr);
                n_grants++;
                cpu_addr = cpu_addr + 32'd4;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("cont_grant_count", n_grants, 32'd6);
        chk("cont_grant_order", {26'd0, order}, 32'b100100);
        chk("cont_done_overlap", {31'd0, flag}, 32'd0);
        step();

        // DMA request withdrawn while the CPU is in its read wait.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30; rd_value = 32'hCAFEF00D;
        step();
        chk("wd_mem_rd", {31'd0, mem_rd}, 32'd1);
        step();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h44; dma_wdata = 32'h44444444;
        step();
        dma_req = 1'b0;
        chk("wd_dma_done_T3", {31'd0, dma_done}, 32'd0);
        step();
        chk("wd_cpu_done", {31'd0, cpu_done}, 32'd1);
        chk("wd_cpu_rdata", cpu_rdata, 32'hCAFEF00D);
        chk("wd_dma_done_T4", {31'd0, dma_done}, 32'd0);
        cpu_req = 1'b0;
        flag = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (mem_wr || mem_rd || dma_done || cpu_done) flag = 1'b1;
        end
        chk("wd_bus_quiet", {31'd0, flag}, 32'd0);

        // DMA read alone: only the DMA port sees done and data.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h70; rd_value = 32'h55AA55AA;
        step();
        chk("dr_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("dr_mem_addr", mem_addr, 32'h70);
        step();
        step();
        step();
        chk("dr_dma_done", {31'd0, dma_done}, 32'd1);
        chk("dr_dma_rdata", dma_rdata, 32'h55AA55AA);
        chk("dr_cpu_done", {31'd0, cpu_done}, 32'd0);
        chk("dr_cpu_rdata_held", cpu_rdata, 32'hCAFEF00D);
        dma_req = 1'b0;
        step();
        chk("dr_dma_rdata_held", dma_rdata, 32'h55AA55AA);

        // Asynchronous reset while the CPU read is in RD_WAIT.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50; rd_value = 32'h0F0F0F0F;
        step();
        chk("ar_mem_addr_pre", mem_addr, 32'h50);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("ar_mem_addr", mem_addr, 32'h0);
        chk("ar_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("ar_cpu_done", {31'd0, cpu_done}, 32'd0);
        chk("ar_cpu_rdata", cpu_rdata, 32'h0);
        chk("ar_dma_rdata", dma_rdata, 32'h0);
        chk("ar_stall", {31'd0, cpu_stall}, 32'd1);
        #1;
        reset = 1'b0;
        cpu_req = 1'b0;
        flag = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (cpu_done || dma_done || mem_rd || mem_wr) flag = 1'b1;
        end
        chk("ar_no_stale_done", {31'd0, flag}, 32'd0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h60; cpu_wdata = 32'h0BADF00D;
        step();
        chk("ar_wr_done", {31'd0, cpu_done}, 32'd1);
        chk("ar_wr_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("ar_wr_addr", mem_addr, 32'h60);
        cpu_req = 1'b0;
        step();

`ifdef ARB_STAT_EN
        // Statistics: 3 CPU reads (4 stall cycles each at MEM_LAT=3) and 2 DMA writes.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("st_stall_rst", {16'd0, stat_cpu_stall_cyc}, 32'd0);
        for (int r = 0; r < 3; r++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80 + 32'(r);
            for (int c = 0; c < 4; c++) step();
            cpu_req = 1'b0;
            step();
        end
        for (int w = 0; w < 2; w++) begin
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h90 + 32'(w);
            step();
            dma_req = 1'b0;
            step();
        end
        chk("st_stall_cyc", {16'd0, stat_cpu_stall_cyc}, 32'd12);
        chk("st_dma_grants", {16'd0, stat_dma_grants}, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
